// File: rtl/tb_ex_trap_gen_if.sv
`timescale 1ns/1ps
// Configuration, start and trap handshake bundle for tb_ex_trap_gen.
// master = the generator (drives trap_valid_o and status), slave = the bench/core side.
interface tb_ex_trap_gen_if #(
    parameter int unsigned CH_NUM = 4,
    parameter int unsigned DLY_W  = 16,
    parameter int unsigned TMO_W  = 16
) ();
    localparam int unsigned CH_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

    logic                cfg_we;
    logic [CH_W-1:0]     cfg_ch;
    logic [DLY_W-1:0]    cfg_delay;
    logic [7:0]          cfg_repeat;
    logic [TMO_W-1:0]    cfg_timeout;
    logic [CH_NUM-1:0]   start;
    logic [CH_NUM-1:0]   trap_valid_o;
    logic [CH_NUM-1:0]   trap_ready_i;
    logic [CH_NUM-1:0]   busy_o;
    logic [CH_NUM-1:0]   done_o;
    logic [CH_NUM-1:0]   tmo_err_o;
    logic [CH_NUM*8-1:0] ack_cnt_o;

    modport master (
        input  cfg_we, cfg_ch, cfg_delay, cfg_repeat, cfg_timeout, start, trap_ready_i,
        output trap_valid_o, busy_o, done_o, tmo_err_o, ack_cnt_o
    );

    modport slave (
        output cfg_we, cfg_ch, cfg_delay, cfg_repeat, cfg_timeout, start, trap_ready_i,
        input  trap_valid_o, busy_o, done_o, tmo_err_o, ack_cnt_o
    );
endinterface

// File: rtl/tb_ex_trap_gen.sv
`timescale 1ns/1ps
// Multi-channel external-interrupt stimulus generator: delayed, repeated valid/ready requests with watchdog.
// Optional: define EX_TRAP_JITTER_EN to add shared-LFSR jitter to every delay load.
module tb_ex_trap_gen #(
    parameter int unsigned CH_NUM      = 4,
    parameter int unsigned DLY_W       = 16,
    parameter int unsigned TMO_W       = 16,
    parameter logic [7:0]  JITTER_MASK = 8'h0F
) (
    input logic              clk,
    input logic              rst,
    tb_ex_trap_gen_if.master bus
);
    localparam int unsigned CH_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_REQ  = 2'd2
    } state_e;

    state_e             state_q [CH_NUM];
    state_e             state_d [CH_NUM];
    logic [DLY_W-1:0]   cfg_dly_q [CH_NUM];
    logic [7:0]         cfg_rep_q [CH_NUM];
    logic [TMO_W-1:0]   cfg_tmo_q [CH_NUM];
    logic [DLY_W-1:0]   wdly_q [CH_NUM];
    logic [DLY_W-1:0]   wdly_d [CH_NUM];
    logic [TMO_W-1:0]   wtmo_q [CH_NUM];
    logic [TMO_W-1:0]   wtmo_d [CH_NUM];
    logic [DLY_W-1:0]   dly_q [CH_NUM];
    logic [DLY_W-1:0]   dly_d [CH_NUM];
    logic [7:0]         rep_q [CH_NUM];
    logic [7:0]         rep_d [CH_NUM];
    logic [TMO_W-1:0]   tcnt_q [CH_NUM];
    logic [TMO_W-1:0]   tcnt_d [CH_NUM];
    logic [7:0]         ack_q [CH_NUM];
    logic [7:0]         ack_d [CH_NUM];
    logic [CH_NUM-1:0]  err_q, err_d, fin_d;
    logic [CH_NUM-1:0]  valid_q, valid_d, busy_q, busy_d, done_q, done_d;
    logic [CH_NUM*8-1:0] ack_flat;

`ifdef EX_TRAP_JITTER_EN
    logic [15:0]  lfsr_q;
    logic [DLY_W:0] jit_w;

    // Galois form of x^16+x^14+x^13+x^11+1, shared by all channels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr_q <= 16'hACE1;
        else     lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end

    assign jit_w = (DLY_W+1)'(lfsr_q[7:0] & JITTER_MASK);

    function automatic logic [DLY_W-1:0] dly_load(input logic [DLY_W-1:0] base);
        logic [DLY_W:0] sum;
        sum = {1'b0, base} + jit_w;
        return sum[DLY_W] ? '1 : sum[DLY_W-1:0];
    endfunction
`else
    function automatic logic [DLY_W-1:0] dly_load(input logic [DLY_W-1:0] base);
        return base;
    endfunction
`endif

    // Config writes land on the edge, so a start on the same edge still sees the old values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < CH_NUM; i++) begin
                cfg_dly_q[i] <= '0;
                cfg_rep_q[i] <= '0;
                cfg_tmo_q[i] <= '0;
            end
        end else if (bus.cfg_we) begin
            for (int unsigned i = 0; i < CH_NUM; i++) begin
                if (bus.cfg_ch == CH_W'(i)) begin
                    cfg_dly_q[i] <= bus.cfg_delay;
                    cfg_rep_q[i] <= bus.cfg_repeat;
                    cfg_tmo_q[i] <= bus.cfg_timeout;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < CH_NUM; i++) begin
                state_q[i] <= S_IDLE;
                wdly_q[i]  <= '0;
                wtmo_q[i]  <= '0;
                dly_q[i]   <= '0;
                rep_q[i]   <= '0;
                tcnt_q[i]  <= '0;
                ack_q[i]   <= '0;
            end
            err_q   <= '0;
            valid_q <= '0;
            busy_q  <= '0;
            done_q  <= '0;
        end else begin
            for (int unsigned i = 0; i < CH_NUM; i++) begin
                state_q[i] <= state_d[i];
                wdly_q[i]  <= wdly_d[i];
                wtmo_q[i]  <= wtmo_d[i];
                dly_q[i]   <= dly_d[i];
                rep_q[i]   <= rep_d[i];
                tcnt_q[i]  <= tcnt_d[i];
                ack_q[i]   <= ack_d[i];
            end
            err_q   <= err_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        err_d = err_q;
        fin_d = '0;
        for (int unsigned i = 0; i < CH_NUM; i++) begin
            state_d[i] = state_q[i];
            wdly_d[i]  = wdly_q[i];
            wtmo_d[i]  = wtmo_q[i];
            dly_d[i]   = dly_q[i];
            rep_d[i]   = rep_q[i];
            tcnt_d[i]  = tcnt_q[i];
            ack_d[i]   = ack_q[i];
            unique case (state_q[i])
                S_IDLE: begin
                    if (bus.start[i]) begin
                        state_d[i] = S_WAIT;
                        wdly_d[i]  = cfg_dly_q[i];
                        wtmo_d[i]  = cfg_tmo_q[i];
                        dly_d[i]   = dly_load(cfg_dly_q[i]);
                        rep_d[i]   = cfg_rep_q[i];
                        ack_d[i]   = '0;
                        err_d[i]   = 1'b0;
                    end
                end
                S_WAIT: begin
                    if (dly_q[i] == '0) begin
                        state_d[i] = S_REQ;
                        tcnt_d[i]  = '0;
                    end else begin
                        dly_d[i] = dly_q[i] - DLY_W'(1);
                    end
                end
                S_REQ: begin
                    tcnt_d[i] = tcnt_q[i] + TMO_W'(1);
                    // Ready is checked first so an ack on the timeout edge still counts.
                    if (bus.trap_ready_i[i]) begin
                        ack_d[i]  = ack_q[i] + 8'd1;
                        tcnt_d[i] = '0;
                        if (rep_q[i] != '0) begin
                            rep_d[i]   = rep_q[i] - 8'd1;
                            dly_d[i]   = dly_load(wdly_q[i]);
                            state_d[i] = S_WAIT;
                        end else begin
                            state_d[i] = S_IDLE;
                            fin_d[i]   = 1'b1;
                        end
                    end else if (wtmo_q[i] != '0 && tcnt_q[i] == wtmo_q[i] - TMO_W'(1)) begin
                        err_d[i]   = 1'b1;
                        state_d[i] = S_IDLE;
                    end
                end
                default: state_d[i] = S_IDLE;
            endcase
        end
    end

    always_comb begin
        valid_d = '0;
        busy_d  = '0;
        done_d  = fin_d;
        for (int unsigned i = 0; i < CH_NUM; i++) begin
            valid_d[i] = (state_d[i] == S_REQ);
            busy_d[i]  = (state_d[i] != S_IDLE);
        end
    end

    always_comb begin
        ack_flat = '0;
        for (int unsigned i = 0; i < CH_NUM; i++) begin
            ack_flat[8*i +: 8] = ack_q[i];
        end
    end

    assign bus.trap_valid_o = valid_q;
    assign bus.busy_o       = busy_q;
    assign bus.done_o       = done_q;
    assign bus.tmo_err_o    = err_q;
    assign bus.ack_cnt_o    = ack_flat;
endmodule

// File: tb/tb_tb_ex_trap_gen.sv
`timescale 1ns/1ps
// Self-checking bench for tb_ex_trap_gen: timestamp-based reference model plus directed scenarios.
module tb_tb_ex_trap_gen;
    localparam int CH = 4;
    localparam int DW = 16;
    localparam int TW = 16;
`ifdef EX_TRAP_JITTER_EN
    localparam int JMAX = 15;
`else
    localparam int JMAX = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;

    tb_ex_trap_gen_if #(.CH_NUM(CH), .DLY_W(DW), .TMO_W(TW)) bus ();

    tb_ex_trap_gen #(.CH_NUM(CH), .DLY_W(DW), .TMO_W(TW), .JITTER_MASK(8'h0F)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d (cycle %0d)", nm, act, lo, hi, cyc);
        end
    endtask

    // Reference model: absolute edge numbers for rise/timeout instead of counters.
    bit   m_busy [CH], m_valid [CH], m_done [CH], m_err [CH];
    int   m_ack [CH], m_reps [CH], m_rise [CH], m_high [CH], m_dly [CH], m_tmo [CH];
    int   c_dly [CH], c_rep [CH], c_tmo [CH];
    int   medge;
    logic [15:0] m_lfsr;

    function automatic int eff_delay(input int base);
`ifdef EX_TRAP_JITTER_EN
        int s;
        s = base + int'(m_lfsr[7:0] & 8'h0F);
        return (s > 65535) ? 65535 : s;
`else
        return base;
`endif
    endfunction

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            for (int c = 0; c < CH; c++) begin
                m_busy[c] = 0; m_valid[c] = 0; m_done[c] = 0; m_err[c] = 0;
                m_ack[c] = 0; m_reps[c] = 0; m_rise[c] = 0; m_high[c] = 0;
                m_dly[c] = 0; m_tmo[c] = 0; c_dly[c] = 0; c_rep[c] = 0; c_tmo[c] = 0;
            end
            medge  = 0;
            m_lfsr = 16'hACE1;
        end else begin
            for (int c = 0; c < CH; c++) begin
                m_done[c] = 0;
                if (!m_busy[c]) begin
                    if (bus.start[c] === 1'b1) begin
                        m_busy[c] = 1; m_dly[c] = c_dly[c]; m_tmo[c] = c_tmo[c];
                        m_reps[c] = c_rep[c]; m_ack[c] = 0; m_err[c] = 0;
                        m_rise[c] = medge + eff_delay(m_dly[c]) + 1;
                    end
                end else if (!m_valid[c]) begin
                    if (medge == m_rise[c]) begin
                        m_valid[c] = 1;
                        m_high[c]  = medge;
                    end
                end else if (bus.trap_ready_i[c] === 1'b1) begin
                    m_ack[c]   = (m_ack[c] + 1) % 256;
                    m_valid[c] = 0;
                    if (m_reps[c] > 0) begin
                        m_reps[c]--;
                        m_rise[c] = medge + eff_delay(m_dly[c]) + 1;
                    end else begin
                        m_busy[c] = 0;
                        m_done[c] = 1;
                    end
                end else if (m_tmo[c] != 0 && medge - m_high[c] == m_tmo[c]) begin
                    m_err[c] = 1; m_valid[c] = 0; m_busy[c] = 0;
                end
            end
            if (bus.cfg_we === 1'b1 && int'(bus.cfg_ch) < CH) begin
                c_dly[bus.cfg_ch] = int'(bus.cfg_delay);
                c_rep[bus.cfg_ch] = int'(bus.cfg_repeat);
                c_tmo[bus.cfg_ch] = int'(bus.cfg_timeout);
            end
            m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
            medge++;
        end
    end

    initial begin : compare_proc
        logic [CH-1:0]   ev, eb, ed, ee;
        logic [8*CH-1:0] ea;
        forever begin
            @(negedge clk);
            for (int c = 0; c < CH; c++) begin
                ev[c] = m_valid[c];
                eb[c] = m_busy[c];
                ed[c] = m_done[c];
                ee[c] = m_err[c];
                ea[8*c +: 8] = 8'(m_ack[c]);
            end
            cmp("model_valid", 32'(bus.trap_valid_o), 32'(ev));
            cmp("model_busy",  32'(bus.busy_o),       32'(eb));
            cmp("model_done",  32'(bus.done_o),       32'(ed));
            cmp("model_err",   32'(bus.tmo_err_o),    32'(ee));
            cmp("model_ack",   bus.ack_cnt_o,         ea);
        end
    end

    task automatic cfg_write(input int ch, input int dly, input int rep, input int tmo);
        bus.cfg_we      = 1'b1;
        bus.cfg_ch      = 2'(ch);
        bus.cfg_delay   = DW'(dly);
        bus.cfg_repeat  = 8'(rep);
        bus.cfg_timeout = TW'(tmo);
        @(posedge clk);
        #1 bus.cfg_we = 1'b0;
    endtask

    task automatic pulse_start(input logic [CH-1:0] mask, output int s);
        bus.start = mask;
        @(posedge clk);
        #1 bus.start = '0;
        s = cyc;
    endtask

    task automatic wait_rise(input int ch, output int r);
        r = -1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (bus.trap_valid_o[ch] === 1'b1) begin
                r = cyc;
                break;
            end
        end
        if (r < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_rise_ch%0d: got no rise in 200 cycles, expected a rise", ch);
        end
    endtask

    task automatic count_pulses(input int ch, input int ncyc, input int glo, input int ghi,
                                output int rises, output int highs, output int dones);
        bit prev;
        int low;
        prev = 0; low = 0; rises = 0; highs = 0; dones = 0;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            if (bus.trap_valid_o[ch] === 1'b1) begin
                highs++;
                if (!prev) begin
                    if (rises > 0) chk_rng($sformatf("gap_ch%0d", ch), low, glo, ghi);
                    rises++;
                end
                low = 0;
            end else begin
                low++;
            end
            if (bus.done_o[ch] === 1'b1) dones++;
            prev = bus.trap_valid_o[ch];
        end
    endtask

    task automatic single_shot(input string tag);
        int s, r;
        cfg_write(0, 5, 0, 0);
        pulse_start(4'b0001, s);
        wait_rise(0, r);
        chk_rng({tag, "_rise"}, r - s, 6, 6 + JMAX);
        repeat (3) @(posedge clk);
        #1 bus.trap_ready_i[0] = 1'b1;
        @(posedge clk);
        #1 bus.trap_ready_i[0] = 1'b0;
        @(negedge clk);
        cmp({tag, "_valid_low"}, 32'(bus.trap_valid_o[0]), 32'd0);
        cmp({tag, "_done"},      32'(bus.done_o[0]),       32'd1);
        cmp({tag, "_ack"},       32'(bus.ack_cnt_o[7:0]),  32'd1);
        cmp({tag, "_busy"},      32'(bus.busy_o[0]),       32'd0);
        @(negedge clk);
        cmp({tag, "_done_1cyc"}, 32'(bus.done_o[0]),       32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected finish within 200us");
        $fatal(1);
    end

    initial begin
        int s, r, s2, r2, rises, highs, dones, hi;
        bus.cfg_we = 1'b0; bus.cfg_ch = '0; bus.cfg_delay = '0; bus.cfg_repeat = '0;
        bus.cfg_timeout = '0; bus.start = '0; bus.trap_ready_i = '0;
        repeat (2) @(negedge clk);
        cmp("reset_valid", 32'(bus.trap_valid_o), 32'd0);
        cmp("reset_busy",  32'(bus.busy_o),       32'd0);
        cmp("reset_ack",   bus.ack_cnt_o,         32'd0);
        rst = 1'b0;
        @(negedge clk);

        single_shot("t1");

        bus.trap_ready_i[1] = 1'b1;
        cfg_write(1, 2, 3, 0);
        pulse_start(4'b0010, s);
        count_pulses(1, 100, 3, 3 + JMAX, rises, highs, dones);
        cmp("t2_pulses", rises, 4);
        cmp("t2_width",  highs, 4);
        cmp("t2_done",   dones, 1);
        cmp("t2_ack",    32'(bus.ack_cnt_o[15:8]), 32'd4);
        bus.trap_ready_i[1] = 1'b0;

        cfg_write(2, 0, 0, 10);
        pulse_start(4'b0100, s);
        wait_rise(2, r);
        chk_rng("t3_rise", r - s, 1, 1 + JMAX);
        hi = 1; dones = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.done_o[2] === 1'b1) dones++;
            if (bus.trap_valid_o[2] !== 1'b1) break;
            hi++;
        end
        cmp("t3_high_cycles", hi, 10);
        cmp("t3_err",  32'(bus.tmo_err_o[2]), 32'd1);
        cmp("t3_done", dones, 0);
        cmp("t3_busy", 32'(bus.busy_o[2]),    32'd0);
        cfg_write(2, 3, 0, 0);
        pulse_start(4'b0100, s);
        @(negedge clk);
        cmp("t3_err_cleared", 32'(bus.tmo_err_o[2]), 32'd0);

        cfg_write(3, 4, 0, 0);
        pulse_start(4'b1000, s);
        cfg_write(3, 1, 0, 0);
        pulse_start(4'b1000, s2);
        wait_rise(3, r);
        chk_rng("t5_old_delay", r - s, 5, 5 + JMAX);
        bus.trap_ready_i[3] = 1'b1;
        @(posedge clk);
        #1 bus.trap_ready_i[3] = 1'b0;
        pulse_start(4'b1000, s2);
        wait_rise(3, r2);
        chk_rng("t5_new_delay", r2 - s2, 2, 2 + JMAX);
        bus.trap_ready_i[3] = 1'b1;
        @(posedge clk);
        #1 bus.trap_ready_i[3] = 1'b0;

        cfg_write(0, 1, 0, 0);
        cfg_write(1, 1, 0, 0);
        cfg_write(3, 1, 0, 0);
        pulse_start(4'b1111, s);
        repeat (4 + JMAX) @(negedge clk);
        cmp("t4_all_valid", 32'(bus.trap_valid_o), 32'hF);
        #2 rst = 1'b1;
        #1;
        cmp("t4_rst_valid", 32'(bus.trap_valid_o), 32'd0);
        cmp("t4_rst_busy",  32'(bus.busy_o),       32'd0);
        cmp("t4_rst_err",   32'(bus.tmo_err_o),    32'd0);
        cmp("t4_rst_ack",   bus.ack_cnt_o,         32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        pulse_start(4'b0010, s);
        wait_rise(1, r);
        chk_rng("t4_cfg_cleared", r - s, 1, 1 + JMAX);
        bus.trap_ready_i[1] = 1'b1;
        @(posedge clk);
        #1 bus.trap_ready_i[1] = 1'b0;
        @(negedge clk);
        single_shot("t4_after");

        bus.trap_ready_i[0] = 1'b1;
        cfg_write(0, 0, 15, 0);
        pulse_start(4'b0001, s);
        count_pulses(0, 400, 1, 1 + JMAX, rises, highs, dones);
        cmp("t6_pulses", rises, 16);
        cmp("t6_width",  highs, 16);
        cmp("t6_done",   dones, 1);
        cmp("t6_ack",    32'(bus.ack_cnt_o[7:0]), 32'd16);
        bus.trap_ready_i[0] = 1'b0;

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
